// File: rtl/vr_pkg.sv
// Shared helpers for valid/ready blocks: width arithmetic and parameter sanity functions.
package vr_pkg;

    localparam int unsigned VR_MIN_DEPTH = 32'd2;

    function automatic int unsigned vr_clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned vr_ptr_w(input int unsigned depth);
        return vr_clog2(depth) + 32'd1;
    endfunction

    function automatic int unsigned vr_cnt_w(input int unsigned depth);
        return vr_clog2(depth + 32'd1);
    endfunction

    function automatic bit vr_is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/vr_fifo_ptr.sv
// Ring-buffer pointer with wrap bit: advances on enable, clears synchronously, resets asynchronously.
module vr_fifo_ptr #(
    parameter int unsigned PW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer: clear wins over advance; binary roll-over provides the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = {PW{1'b0}};
        end else if (en_i) begin
            ptr_d = ptr_q + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/valid_ready_fifo.sv
// Valid/ready elastic buffer: DEPTH-entry ring with registered occupancy count, almost-full and flush.
module valid_ready_fifo
    import vr_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            data_up,
    input  logic                        valid_up,
    output logic                        ready_up,
    output logic [WIDTH-1:0]            data_down,
    output logic                        valid_down,
    input  logic                        ready_down,
    output logic [vr_cnt_w(DEPTH)-1:0]  count,
    output logic                        almost_full
);

    localparam int unsigned AW = vr_clog2(DEPTH);
    localparam int unsigned PW = vr_ptr_w(DEPTH);
    localparam int unsigned CW = vr_cnt_w(DEPTH);

    if (!vr_is_pow2(DEPTH) || (DEPTH < VR_MIN_DEPTH) ||
        (AF_LEVEL < 32'd1) || (AF_LEVEL > DEPTH)) begin : g_param_check
        $fatal(1, "valid_ready_fifo: DEPTH must be a power of two >= 2 and 1 <= AF_LEVEL <= DEPTH");
    end

    logic [PW-1:0]    wr_ptr_s;
    logic [PW-1:0]    rd_ptr_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             af_q;
    logic             af_d;

    // Handshake qualifiers depend only on registered pointers and flush, so no ready/valid path crosses the buffer.
    assign empty_s    = (wr_ptr_s == rd_ptr_s);
    assign full_s     = (wr_ptr_s[AW] != rd_ptr_s[AW]) &&
                        (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
    assign ready_up   = ~full_s & ~flush;
    assign valid_down = ~empty_s & ~flush;
    assign push_s     = valid_up & ready_up;
    assign pop_s      = valid_down & ready_down;
    assign data_down  = valid_down ? mem_q[rd_ptr_s[AW-1:0]] : {WIDTH{1'b0}};

    vr_fifo_ptr #(.PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (push_s),
        .ptr_o (wr_ptr_s)
    );

    vr_fifo_ptr #(.PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (pop_s),
        .ptr_o (rd_ptr_s)
    );

    // Storage write; contents are not reset because empty/full come from the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_s[AW-1:0]] <= data_up;
        end
    end

    // Occupancy next-state and the almost-full flag derived from it.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
        af_d = (count_d >= CW'(AF_LEVEL));
    end

    // Count and almost-full registers, updated together so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
            af_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            af_q    <= af_d;
        end
    end

    assign count       = count_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Self-checking bench for valid_ready_fifo (WIDTH=4, DEPTH=4, AF_LEVEL=3) with a queue scoreboard.
module tb_valid_ready_fifo;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int AF = 3;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [W-1:0] data_up;
    logic         valid_up;
    logic         ready_up;
    logic [W-1:0] data_down;
    logic         valid_down;
    logic         ready_down;
    logic [2:0]   count;
    logic         almost_full;

    int           vecs;
    int           errs;
    logic [W-1:0] sb[$];

    valid_ready_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .data_up     (data_up),
        .valid_up    (valid_up),
        .ready_up    (ready_up),
        .data_down   (data_down),
        .valid_down  (valid_down),
        .ready_down  (ready_down),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances one clock and updates the scoreboard with the handshakes the bench expects.
    task automatic model_step();
        bit do_push;
        bit do_pop;
        do_push = valid_up && !flush && (sb.size() < D);
        do_pop  = ready_down && !flush && (sb.size() > 0);
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(data_up);
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (ready_up !== 1'b1) begin $display("FAIL reset_ready_up got %b want 1", ready_up); errs++; end
        vecs++; if (valid_down !== 1'b0) begin $display("FAIL reset_valid_down got %b want 0", valid_down); errs++; end
        vecs++; if (count !== 3'd0) begin $display("FAIL reset_count got %0d want 0", count); errs++; end
        #2 rst = 1'b0;
        valid_up = 1'b1;
        data_up  = 4'h5;
        model_step();
        model_step();
        #3 rst = 1'b1;
        #1;
        sb.delete();
        vecs++; if (ready_up !== 1'b1) begin $display("FAIL midrst_ready_up got %b want 1", ready_up); errs++; end
        vecs++; if (valid_down !== 1'b0) begin $display("FAIL midrst_valid_down got %b want 0", valid_down); errs++; end
        vecs++; if (count !== 3'd0) begin $display("FAIL midrst_count got %0d want 0", count); errs++; end
        vecs++; if (data_down !== 4'h0) begin $display("FAIL midrst_data_down got %h want 0", data_down); errs++; end
        vecs++; if (almost_full !== 1'b0) begin $display("FAIL midrst_almost_full got %b want 0", almost_full); errs++; end
        valid_up = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        model_step();
        vecs++; if (valid_down !== 1'b0) begin $display("FAIL rst_release_valid got %b want 0", valid_down); errs++; end
        vecs++; if (count !== 3'd0) begin $display("FAIL rst_release_count got %0d want 0", count); errs++; end
    endtask

    task automatic test_fill();
        ready_down = 1'b0;
        valid_up   = 1'b1;
        for (int i = 0; i < D; i++) begin
            logic exp_af;
            exp_af  = (i >= AF);
            data_up = 4'(i + 1);
            #1;
            vecs++; if (count !== 3'(i)) begin $display("FAIL fill_count got %0d want %0d", count, i); errs++; end
            vecs++; if (ready_up !== 1'b1) begin $display("FAIL fill_ready_up got %b want 1", ready_up); errs++; end
            vecs++; if (almost_full !== exp_af) begin $display("FAIL fill_almost_full got %b want %b", almost_full, exp_af); errs++; end
            model_step();
        end
        data_up = 4'h5;
        #1;
        vecs++; if (count !== 3'd4) begin $display("FAIL full_count got %0d want 4", count); errs++; end
        vecs++; if (ready_up !== 1'b0) begin $display("FAIL full_ready_up got %b want 0", ready_up); errs++; end
        vecs++; if (almost_full !== 1'b1) begin $display("FAIL full_almost_full got %b want 1", almost_full); errs++; end
        vecs++; if (data_down !== 4'h1) begin $display("FAIL full_head got %h want 1", data_down); errs++; end
        model_step();
        vecs++; if (count !== 3'd4) begin $display("FAIL held_count got %0d want 4", count); errs++; end
        vecs++; if (ready_up !== 1'b0) begin $display("FAIL held_ready_up got %b want 0", ready_up); errs++; end
        valid_up = 1'b0;
    endtask

    task automatic test_drain();
        valid_up   = 1'b0;
        ready_down = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1;
            vecs++; if (valid_down !== 1'b1) begin $display("FAIL drain_valid got %b want 1", valid_down); errs++; end
            vecs++; if (sb.size() == 0 || data_down !== sb[0]) begin $display("FAIL drain_data got %h want %h", data_down, (sb.size() > 0) ? sb[0] : 4'hx); errs++; end
            vecs++; if (count !== 3'(D - i)) begin $display("FAIL drain_count got %0d want %0d", count, D - i); errs++; end
            model_step();
        end
        #1;
        vecs++; if (valid_down !== 1'b0) begin $display("FAIL drained_valid got %b want 0", valid_down); errs++; end
        vecs++; if (count !== 3'd0) begin $display("FAIL drained_count got %0d want 0", count); errs++; end
        vecs++; if (data_down !== 4'h0) begin $display("FAIL drained_data got %h want 0", data_down); errs++; end
        ready_down = 1'b0;
    endtask

    task automatic test_streaming();
        valid_up   = 1'b1;
        ready_down = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data_up = 4'(i);
            #1;
            if (i == 0) begin
                vecs++; if (valid_down !== 1'b0) begin $display("FAIL stream_no_fallthrough got %b want 0", valid_down); errs++; end
            end else begin
                vecs++; if (valid_down !== 1'b1) begin $display("FAIL stream_valid cyc %0d got %b want 1", i, valid_down); errs++; end
                vecs++; if (data_down !== 4'(i - 1)) begin $display("FAIL stream_data cyc %0d got %h want %h", i, data_down, 4'(i - 1)); errs++; end
                vecs++; if (count !== 3'd1) begin $display("FAIL stream_count cyc %0d got %0d want 1", i, count); errs++; end
                vecs++; if (ready_up !== 1'b1) begin $display("FAIL stream_ready cyc %0d got %b want 1", i, ready_up); errs++; end
            end
            model_step();
        end
        valid_up = 1'b0;
        #1;
        vecs++; if (sb.size() == 0 || data_down !== sb[0]) begin $display("FAIL stream_last got %h want %h", data_down, 4'(99)); errs++; end
        model_step();
        vecs++; if (valid_down !== 1'b0) begin $display("FAIL stream_empty got %b want 0", valid_down); errs++; end
        ready_down = 1'b0;
    endtask

    task automatic test_full_pop();
        ready_down = 1'b0;
        valid_up   = 1'b1;
        for (int i = 0; i < D; i++) begin
            data_up = 4'(4'hA + i);
            model_step();
        end
        ready_down = 1'b1;
        data_up    = 4'hE;
        #1;
        vecs++; if (ready_up !== 1'b0) begin $display("FAIL fullpop_no_bypass got %b want 0", ready_up); errs++; end
        vecs++; if (count !== 3'd4) begin $display("FAIL fullpop_count0 got %0d want 4", count); errs++; end
        vecs++; if (data_down !== 4'hA) begin $display("FAIL fullpop_head got %h want a", data_down); errs++; end
        model_step();
        vecs++; if (ready_up !== 1'b1) begin $display("FAIL fullpop_ready_next got %b want 1", ready_up); errs++; end
        vecs++; if (count !== 3'd3) begin $display("FAIL fullpop_count1 got %0d want 3", count); errs++; end
        data_up = 4'hF;
        model_step();
        vecs++; if (count !== 3'd3) begin $display("FAIL fullpop_count2 got %0d want 3", count); errs++; end
        model_step();
        vecs++; if (count !== 3'd3) begin $display("FAIL fullpop_count3 got %0d want 3", count); errs++; end
        valid_up = 1'b0;
        for (int i = 0; i < D + 2; i++) begin
            #1;
            if (sb.size() > 0) begin
                vecs++; if (valid_down !== 1'b1 || data_down !== sb[0]) begin $display("FAIL fullpop_drain got %b/%h want 1/%h", valid_down, data_down, sb[0]); errs++; end
            end else begin
                vecs++; if (valid_down !== 1'b0) begin $display("FAIL fullpop_drained got %b want 0", valid_down); errs++; end
            end
            model_step();
        end
        ready_down = 1'b0;
    endtask

    task automatic test_flush();
        ready_down = 1'b0;
        valid_up   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_up = 4'(i + 1);
            model_step();
        end
        valid_up = 1'b0;
        #1;
        vecs++; if (count !== 3'd3) begin $display("FAIL preflush_count got %0d want 3", count); errs++; end
        flush      = 1'b1;
        valid_up   = 1'b1;
        ready_down = 1'b1;
        data_up    = 4'h9;
        #1;
        vecs++; if (ready_up !== 1'b0) begin $display("FAIL flush_ready_up got %b want 0", ready_up); errs++; end
        vecs++; if (valid_down !== 1'b0) begin $display("FAIL flush_valid_down got %b want 0", valid_down); errs++; end
        vecs++; if (data_down !== 4'h0) begin $display("FAIL flush_data_down got %h want 0", data_down); errs++; end
        model_step();
        flush      = 1'b0;
        valid_up   = 1'b0;
        ready_down = 1'b0;
        #1;
        vecs++; if (count !== 3'd0) begin $display("FAIL postflush_count got %0d want 0", count); errs++; end
        vecs++; if (valid_down !== 1'b0) begin $display("FAIL postflush_valid got %b want 0", valid_down); errs++; end
        vecs++; if (almost_full !== 1'b0) begin $display("FAIL postflush_af got %b want 0", almost_full); errs++; end
        valid_up = 1'b1;
        data_up  = 4'h7;
        model_step();
        data_up  = 4'h8;
        model_step();
        valid_up   = 1'b0;
        ready_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] exp_d;
            exp_d = (i == 0) ? 4'h7 : 4'h8;
            #1;
            if (i < 2) begin
                vecs++; if (valid_down !== 1'b1 || data_down !== exp_d) begin $display("FAIL postflush_data got %b/%h want 1/%h", valid_down, data_down, exp_d); errs++; end
            end else begin
                vecs++; if (valid_down !== 1'b0) begin $display("FAIL postflush_dup got %b want 0", valid_down); errs++; end
            end
            model_step();
        end
        ready_down = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic         exp_rdy;
            logic         exp_vld;
            logic         exp_af;
            logic [W-1:0] exp_d;
            valid_up   = ($urandom_range(0, 9) < 7);
            ready_down = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 49) == 0);
            data_up    = 4'($urandom);
            #1;
            exp_rdy = (sb.size() < D) && !flush;
            exp_vld = (sb.size() > 0) && !flush;
            exp_af  = (sb.size() >= AF);
            exp_d   = exp_vld ? sb[0] : 4'h0;
            vecs++; if (ready_up !== exp_rdy) begin $display("FAIL rand_ready_up cyc %0d got %b want %b", n, ready_up, exp_rdy); errs++; end
            vecs++; if (valid_down !== exp_vld) begin $display("FAIL rand_valid_down cyc %0d got %b want %b", n, valid_down, exp_vld); errs++; end
            vecs++; if (data_down !== exp_d) begin $display("FAIL rand_data cyc %0d got %h want %h", n, data_down, exp_d); errs++; end
            vecs++; if (count !== 3'(sb.size())) begin $display("FAIL rand_count cyc %0d got %0d want %0d", n, count, sb.size()); errs++; end
            vecs++; if (almost_full !== exp_af) begin $display("FAIL rand_af cyc %0d got %b want %b", n, almost_full, exp_af); errs++; end
            model_step();
        end
        flush      = 1'b0;
        valid_up   = 1'b0;
        ready_down = 1'b0;
    endtask

    initial begin
        vecs       = 0;
        errs       = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        data_up    = 4'h0;
        valid_up   = 1'b0;
        ready_down = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_full_pop();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
